barcode_frame_sequencer: RTL and testbench

Sequencer that shares one check-digit unit (the `D` module) between two client request ports (A, B) and emits a 5-nibble barcode frame per granted request over a valid/ready digit stream. It sits between the client/time-button pricing logic, which produces `valueToPay` per client, and the barcode display/printer driver. It arbitrates round-robin, validates the amount, obtains the check digit and serialises the frame.

---
 rtl/barcode_pkg.sv | 20 ++
 rtl/D.sv | 18 +
 rtl/rr_arbiter2.sv | 15 +
 rtl/barcode_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_barcode_frame_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/barcode_pkg.sv
// rtl/barcode_pkg.sv - shared types, constants and amount legality for the barcode frame sequencer
package barcode_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, SEND, DONE, ERR} state_t;

  localparam int         FRAME_LEN   = 5;
  localparam int         CHECK_BASE  = 54;
  localparam int         CHECK_MOD   = 15;
  localparam logic [3:0] CLIENT_ID_A = 4'd1;
  localparam logic [3:0] CLIENT_ID_B = 4'd2;

  function automatic logic is_legal_amount(input logic [4:0] amount);
    case (amount)
      5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14, 5'd16,
      5'd20, 5'd24, 5'd28: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/D.sv
// rtl/D.sv - check-digit unit: (CHECK_BASE + amount) mod CHECK_MOD plus amount legality
module D
  import barcode_pkg::*;
(
  input  logic [4:0] value,
  output logic [3:0] check,
  output logic       legal
);

  logic [6:0] sum;

  always_comb begin
    sum   = 7'(CHECK_BASE) + {2'b00, value};
    check = 4'(sum % 7'(CHECK_MOD));
    legal = is_legal_amount(value);
  end

endmodule

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant; last_grant 0 = A, 1 = B
module rr_arbiter2 (
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = req_a & (~req_b | last_grant);
    grant[1] = req_b & ~grant[0];
  end

endmodule

// File: rtl/barcode_frame_sequencer.sv
// rtl/barcode_frame_sequencer.sv - arbitrates two clients, validates the amount and streams a 5-nibble barcode frame
module barcode_frame_sequencer
  import barcode_pkg::*;
#(
  parameter logic [3:0] FRAME_HEADER = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reqA,
  input  logic [4:0] valueA,
  input  logic       reqB,
  input  logic [4:0] valueB,
  output logic       ackA,
  output logic       ackB,
  output logic       errA,
  output logic       errB,
  output logic [3:0] digitOut,
  output logic       digitValid,
  input  logic       digitReady,
  output logic       digitLast,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [2:0] index_q, index_d;
  logic [4:0] value_q, value_d;
  logic       client_q, client_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] check_q, check_d;
  logic [3:0] digit_q, digit_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic       err_a_q, err_a_d, err_b_q, err_b_d;

  logic [1:0] grant;
  logic [3:0] d_check;
  logic       d_legal;
  logic       handshake;
  logic [3:0] tens, units;
  logic [4:0] tens_weight;

  rr_arbiter2 u_arb (
    .req_a      (reqA),
    .req_b      (reqB),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  D u_d (
    .value (value_q),
    .check (d_check),
    .legal (d_legal)
  );

  assign handshake = valid_q & digitReady;

  always_comb begin
    tens        = 4'd0;
    tens_weight = 5'd0;
    if (value_q >= 5'd20) begin
      tens        = 4'd2;
      tens_weight = 5'd20;
    end else if (value_q >= 5'd10) begin
      tens        = 4'd1;
      tens_weight = 5'd10;
    end
    units = 4'(value_q - tens_weight);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      index_q      <= 3'd0;
      value_q      <= 5'd0;
      client_q     <= 1'b0;
      last_grant_q <= 1'b1;
      check_q      <= 4'd0;
      digit_q      <= 4'd0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      err_a_q      <= 1'b0;
      err_b_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      value_q      <= value_d;
      client_q     <= client_d;
      last_grant_q <= last_grant_d;
      check_q      <= check_d;
      digit_q      <= digit_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      err_a_q      <= err_a_d;
      err_b_q      <= err_b_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    value_d      = value_q;
    client_d     = client_q;
    last_grant_d = last_grant_q;
    check_d      = check_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          value_d  = grant[1] ? valueB : valueA;
          client_d = grant[1];
          state_d  = CHECK;
        end
      end
      CHECK: begin
        check_d = d_check;
        index_d = 3'd0;
        state_d = d_legal ? SEND : ERR;
      end
      SEND: begin
        if (handshake) begin
          if (index_q == 3'(FRAME_LEN - 1)) state_d = DONE;
          else                              index_d = index_q + 3'd1;
        end
      end
      DONE, ERR: begin
        last_grant_d = client_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stream outputs are registered from the next state, so they change only on a handshake.
  always_comb begin
    valid_d = (state_d == SEND);
    last_d  = valid_d && (index_d == 3'(FRAME_LEN - 1));
    digit_d = 4'd0;
    if (valid_d) begin
      case (index_d)
        3'd0:    digit_d = FRAME_HEADER;
        3'd1:    digit_d = client_q ? CLIENT_ID_B : CLIENT_ID_A;
        3'd2:    digit_d = tens;
        3'd3:    digit_d = units;
        default: digit_d = check_d;
      endcase
    end
    ack_a_d = (state_d == DONE) && !client_q;
    ack_b_d = (state_d == DONE) &&  client_q;
    err_a_d = (state_d == ERR)  && !client_q;
    err_b_d = (state_d == ERR)  &&  client_q;
  end

  assign digitOut   = digit_q;
  assign digitValid = valid_q;
  assign digitLast  = last_q;
  assign ackA       = ack_a_q;
  assign ackB       = ack_b_q;
  assign errA       = err_a_q;
  assign errB       = err_b_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_barcode_frame_sequencer.sv
// tb/tb_barcode_frame_sequencer.sv - self-checking bench for barcode_frame_sequencer
module tb_barcode_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reqA = 1'b0, reqB = 1'b0;
  logic [4:0] valueA = 5'd0, valueB = 5'd0;
  logic       ackA, ackB, errA, errB;
  logic [3:0] digitOut;
  logic       digitValid, digitLast, busy;
  logic       digitReady = 1'b1;
  logic [10:0] outs;

  int total = 0;
  int bad   = 0;

  barcode_frame_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reqA       (reqA),
    .valueA     (valueA),
    .reqB       (reqB),
    .valueB     (valueB),
    .ackA       (ackA),
    .ackB       (ackB),
    .errA       (errA),
    .errB       (errB),
    .digitOut   (digitOut),
    .digitValid (digitValid),
    .digitReady (digitReady),
    .digitLast  (digitLast),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign outs = {ackA, ackB, errA, errB, digitOut, digitValid, digitLast, busy};

  // Reference model: events 0=ackA 1=ackB 2=errA 3=errB; model_last 0=A 1=B
  int legal_tbl[11] = '{2, 4, 6, 8, 10, 12, 14, 16, 20, 24, 28};
  int model_last;
  int exp_q[$], exp_last_q[$], exp_ev[$];
  int nib_q[$], last_q[$], ev_q[$];
  bit busy_hist[$];
  int cyc, first_valid, first_ack, first_err;

  function automatic bit legal(input int amt);
    foreach (legal_tbl[i]) if (legal_tbl[i] == amt) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_frame(input int client, input int amt);
    exp_q.push_back(15);
    exp_q.push_back(client + 1);
    exp_q.push_back(amt / 10);
    exp_q.push_back(amt % 10);
    exp_q.push_back((54 + amt) % 15);
    for (int i = 0; i < 5; i++) exp_last_q.push_back(i == 4 ? 1 : 0);
  endfunction

  function automatic void model_requests(input bit pa_in, input bit pb_in, input int va, input int vb);
    bit pa = pa_in, pb = pb_in;
    int g, amt;
    while (pa || pb) begin
      g   = (pa && pb) ? (model_last == 1 ? 0 : 1) : (pa ? 0 : 1);
      amt = g ? vb : va;
      if (legal(amt)) begin
        model_frame(g, amt);
        exp_ev.push_back(g);
      end else begin
        exp_ev.push_back(2 + g);
      end
      model_last = g;
      if (g) pb = 1'b0; else pa = 1'b0;
    end
  endfunction

  function automatic bit streams_equal();
    if (nib_q.size() != exp_q.size() || last_q.size() != exp_last_q.size()) return 1'b0;
    foreach (exp_q[i]) if (nib_q[i] != exp_q[i] || last_q[i] != exp_last_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit events_equal();
    if (ev_q.size() != exp_ev.size()) return 1'b0;
    foreach (exp_ev[i]) if (ev_q[i] != exp_ev[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_log();
    cyc = 0; first_valid = -1; first_ack = -1; first_err = -1;
    exp_q.delete(); exp_last_q.delete(); exp_ev.delete();
    nib_q.delete(); last_q.delete(); ev_q.delete(); busy_hist.delete();
  endtask

  // Requests must be driven before the call; the first posedge of the loop is edge N.
  task automatic run(input int n, input bit rand_ready, input bit scramble, input int stop_ev);
    logic [3:0] prev_digit = 4'd0;
    bit prev_stall = 1'b0;
    int tail = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      busy_hist.push_back(busy);
      if (digitValid && first_valid < 0) first_valid = cyc;
      if ((ackA || ackB) && first_ack < 0) first_ack = cyc;
      if ((errA || errB) && first_err < 0) first_err = cyc;
      if (prev_stall) begin
        total++;
        if (!digitValid || digitOut !== prev_digit) begin
          bad++;
          $display("FAIL stall_hold: cyc=%0d valid=%0b digit=%0d required valid=1 digit=%0d", cyc, digitValid, digitOut, prev_digit);
        end
      end
      if (ackA) begin ev_q.push_back(0); reqA = 1'b0; end
      if (ackB) begin ev_q.push_back(1); reqB = 1'b0; end
      if (errA) begin ev_q.push_back(2); reqA = 1'b0; end
      if (errB) begin ev_q.push_back(3); reqB = 1'b0; end
      if (scramble && cyc >= 1) begin valueA = 5'($urandom); valueB = 5'($urandom); end
      digitReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (digitValid && digitReady) begin
        nib_q.push_back(int'(digitOut));
        last_q.push_back(int'(digitLast));
      end
      prev_stall = digitValid && !digitReady;
      prev_digit = digitOut;
      if (stop_ev > 0 && tail < 0 && ev_q.size() >= stop_ev) tail = 3;
      if (tail > 0) begin
        tail--;
        if (tail == 0) break;
      end
    end
    digitReady = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; reqA = 1'b1; reqB = 1'b1; valueA = 5'd10; valueB = 5'd24;
    repeat (2) @(negedge clk);
    total++;
    if (outs !== 11'd0) begin bad++; $display("FAIL reset_outputs: got %b required 0", outs); end
    reqA = 1'b0; reqB = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (outs !== 11'd0) begin bad++; $display("FAIL post_reset_idle: got %b required 0", outs); end
    model_last = 1;
  endtask

  task automatic test_frame_a();
    clear_log();
    valueA = 5'd10; reqA = 1'b1; digitReady = 1'b1;
    model_requests(1'b1, 1'b0, 10, 0);
    run(30, 1'b0, 1'b1, 1);
    total++;
    if (!streams_equal()) begin bad++; $display("FAIL frame_a_stream: got %p required %p", nib_q, exp_q); end
    total++;
    if (first_valid != 2) begin bad++; $display("FAIL frame_a_first_valid: got %0d required 2", first_valid); end
    total++;
    if (first_ack != 7) begin bad++; $display("FAIL frame_a_ack_cycle: got %0d required 7", first_ack); end
    total++;
    if (!events_equal()) begin bad++; $display("FAIL frame_a_events: got %p required %p", ev_q, exp_ev); end
  endtask

  task automatic test_frame_b();
    clear_log();
    valueB = 5'd24; reqB = 1'b1;
    model_requests(1'b0, 1'b1, 0, 24);
    run(30, 1'b0, 1'b1, 1);
    total++;
    if (!streams_equal()) begin bad++; $display("FAIL frame_b_stream: got %p required %p", nib_q, exp_q); end
    total++;
    if (!events_equal()) begin bad++; $display("FAIL frame_b_events: got %p required %p", ev_q, exp_ev); end
  endtask

  task automatic test_tie();
    test_reset();
    clear_log();
    valueA = 5'd2; valueB = 5'd28; reqA = 1'b1; reqB = 1'b1;
    model_requests(1'b1, 1'b1, 2, 28);
    run(60, 1'b0, 1'b0, 2);
    total++;
    if (!streams_equal()) begin bad++; $display("FAIL tie_stream: got %p required %p", nib_q, exp_q); end
    total++;
    if (!events_equal()) begin bad++; $display("FAIL tie_order: got %p required %p", ev_q, exp_ev); end
    clear_log();
    valueA = 5'd6; valueB = 5'd12; reqA = 1'b1; reqB = 1'b1;
    model_requests(1'b1, 1'b1, 6, 12);
    run(60, 1'b0, 1'b0, 2);
    total++;
    if (!events_equal()) begin bad++; $display("FAIL tie_alternate: got %p required %p", ev_q, exp_ev); end
    total++;
    if (!streams_equal()) begin bad++; $display("FAIL tie_alt_stream: got %p required %p", nib_q, exp_q); end
  endtask

  task automatic test_illegal();
    clear_log();
    valueA = 5'd18; reqA = 1'b1;
    model_requests(1'b1, 1'b0, 18, 0);
    run(8, 1'b0, 1'b0, 0);
    total++;
    if (first_err != 2) begin bad++; $display("FAIL illegal_err_cycle: got %0d required 2", first_err); end
    total++;
    if (first_valid != -1) begin bad++; $display("FAIL illegal_valid: got first valid %0d required none", first_valid); end
    total++;
    if (busy_hist[1] !== 1'b1 || busy_hist[2] !== 1'b0) begin
      bad++; $display("FAIL illegal_busy: got c2=%0b c3=%0b required c2=1 c3=0", busy_hist[1], busy_hist[2]);
    end
    total++;
    if (!events_equal()) begin bad++; $display("FAIL illegal_events: got %p required %p", ev_q, exp_ev); end
  endtask

  task automatic test_backpressure();
    clear_log();
    valueB = 5'd20; reqB = 1'b1;
    model_requests(1'b0, 1'b1, 0, 20);
    run(200, 1'b1, 1'b1, 1);
    total++;
    if (!streams_equal()) begin bad++; $display("FAIL bp_stream: got %p required %p", nib_q, exp_q); end
    total++;
    if (!events_equal()) begin bad++; $display("FAIL bp_single_ack: got %p required %p", ev_q, exp_ev); end
  endtask

  task automatic test_reset_mid_frame();
    int amt = legal_tbl[$urandom_range(0, 10)];
    clear_log();
    valueA = 5'(amt); reqA = 1'b1;
    run(3, 1'b0, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (!digitValid || int'(digitOut) != amt / 10) begin
      bad++; $display("FAIL mid_frame_index2: got valid=%0b digit=%0d required valid=1 digit=%0d", digitValid, digitOut, amt / 10);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (outs !== 11'd0) begin bad++; $display("FAIL mid_frame_reset_outputs: got %b required 0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    clear_log();
    model_requests(1'b1, 1'b0, amt, 0);
    run(30, 1'b0, 1'b0, 1);
    total++;
    if (!streams_equal()) begin bad++; $display("FAIL restart_stream: got %p required %p", nib_q, exp_q); end
    total++;
    if (!events_equal() || first_valid != 2) begin
      bad++; $display("FAIL restart_events: got %p first_valid=%0d required %p first_valid=2", ev_q, first_valid, exp_ev);
    end
  endtask

  task automatic test_random();
    bit pa, pb;
    int va, vb;
    for (int it = 0; it < 30; it++) begin
      clear_log();
      pa = 1'($urandom_range(0, 1));
      pb = pa ? 1'($urandom_range(0, 1)) : 1'b1;
      va = ($urandom_range(0, 9) < 7) ? legal_tbl[$urandom_range(0, 10)] : int'($urandom_range(0, 31));
      vb = ($urandom_range(0, 9) < 7) ? legal_tbl[$urandom_range(0, 10)] : int'($urandom_range(0, 31));
      valueA = 5'(va); valueB = 5'(vb); reqA = pa; reqB = pb;
      model_requests(pa, pb, va, vb);
      run(400, 1'b1, 1'b0, exp_ev.size());
      total++;
      if (!events_equal()) begin bad++; $display("FAIL random_events it=%0d: got %p required %p", it, ev_q, exp_ev); end
      total++;
      if (!streams_equal()) begin bad++; $display("FAIL random_stream it=%0d: got %p required %p", it, nib_q, exp_q); end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a();
    test_frame_b();
    test_tie();
    test_illegal();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
